// File: rtl/bec_key_sched_if.sv
// Operand load port between the SoC front-end (master) and the BEC
// host-side sequencer (slave).
//   op_valid / op_ready : handshake, transfer on a cycle where both are high
//   op_sel              : operand code 0..5 (6 and 7 are illegal)
//   op_data             : operand value
interface bec_key_sched_if #(
  parameter int DATA_W = 163
) ();
  logic              op_valid;
  logic              op_ready;
  logic [2:0]        op_sel;
  logic [DATA_W-1:0] op_data;

  modport master (output op_valid, output op_sel, output op_data, input op_ready);
  modport slave  (input op_valid, input op_sel, input op_data, output op_ready);
endinterface

// File: rtl/bec_key_sched.sv
// Host-side sequencer for the GF(2^163) binary Edwards curve scalar-mult core.
// One core run per accepted start: capture scalar, stream six operands into
// the core, launch it, feed one scalar bit per ladder iteration on core_ki,
// then unload the two result words.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset (shared with core)
//   start, key        : run request (sampled in IDLE only) and scalar
//   op                : operand load port (bec_key_sched_if.slave)
//   busy              : high in every state except IDLE
//   res_x, res_z      : results, held until the next accepted start
//   res_valid         : one-cycle pulse once both results are captured
//   err               : sticky error, cleared by accepted start
//   core_*            : control/data to and from the BEC core
//
// Optional build macro BEC_SCHED_ITERCHK_EN: counts core_next_key pulses
// during RUN and flags err when the count at core_done differs from KEY_W.
module bec_key_sched #(
  parameter int KEY_W  = 163,
  parameter int DATA_W = 163
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [KEY_W-1:0]  key,
  bec_key_sched_if.slave    op,
  output logic              busy,
  output logic [DATA_W-1:0] res_x,
  output logic [DATA_W-1:0] res_z,
  output logic              res_valid,
  output logic              err,
  output logic              core_load_data,
  output logic              core_enable,
  output logic              core_trigLoad,
  output logic              core_ki,
  output logic [2:0]        core_load_status,
  output logic [DATA_W-1:0] core_data_in,
  input  logic              core_next_key,
  input  logic              core_done,
  input  logic [3:0]        core_status,
  input  logic [DATA_W-1:0] core_data_out
);

  typedef enum logic [3:0] {IDLE, REQ, WDL, LOAD, GO, RUN, UPA, UPB, FIN} state_e;

  localparam logic [5:0] MASK_ALL = 6'b111111;

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [5:0]        mask_q, mask_d;
  logic [2:0]        ls_q, ls_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              trig_q, trig_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rz_q, rz_d;
  logic              iter_err;

  // Only the download flag of the core status is consulted.
  logic unused_status;
  assign unused_status = ^{core_status[3], core_status[1:0]};

`ifdef BEC_SCHED_ITERCHK_EN
  logic [7:0] it_cnt_q, it_cnt_d;

  always_comb begin
    it_cnt_d = it_cnt_q;
    if (state_q == REQ)
      it_cnt_d = '0;
    else if (state_q == RUN && core_next_key)
      it_cnt_d = it_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) it_cnt_q <= '0;
    else     it_cnt_q <= it_cnt_d;
  end

  // it_cnt_d already includes a pulse arriving together with core_done.
  assign iter_err = (it_cnt_d != 8'(KEY_W));
`else
  assign iter_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    mask_d  = mask_q;
    ls_d    = ls_q;
    din_d   = din_q;
    trig_d  = 1'b0;
    err_d   = err_q;
    rx_d    = rx_q;
    rz_d    = rz_q;
    case (state_q)
      IDLE: if (start) begin
        key_d   = key;
        err_d   = 1'b0;
        mask_d  = '0;
        rx_d    = '0;
        rz_d    = '0;
        state_d = REQ;
      end
      REQ: state_d = WDL;
      WDL: if (core_status[2]) state_d = LOAD;
      LOAD: begin
        // Full mask means the last trigLoad is on the wire this cycle.
        if (mask_q == MASK_ALL)
          state_d = GO;
        else if (op.op_valid) begin
          if (op.op_sel <= 3'd5) begin
            ls_d             = op.op_sel;
            din_d            = op.op_data;
            trig_d           = 1'b1;
            mask_d[op.op_sel] = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      GO: state_d = RUN;
      RUN: begin
        if (core_next_key) key_d = {key_q[KEY_W-2:0], 1'b0};
        if (core_done) begin
          if (iter_err) err_d = 1'b1;
          ls_d    = 3'd0;
          state_d = UPA;
        end
      end
      UPA: begin
        rx_d    = core_data_out;
        ls_d    = 3'd1;
        state_d = UPB;
      end
      UPB: begin
        rz_d    = core_data_out;
        ls_d    = 3'd0;
        state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      mask_q  <= '0;
      ls_q    <= '0;
      din_q   <= '0;
      trig_q  <= 1'b0;
      err_q   <= 1'b0;
      rx_q    <= '0;
      rz_q    <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      mask_q  <= mask_d;
      ls_q    <= ls_d;
      din_q   <= din_d;
      trig_q  <= trig_d;
      err_q   <= err_d;
      rx_q    <= rx_d;
      rz_q    <= rz_d;
    end
  end

  assign op.op_ready       = (state_q == LOAD) && (mask_q != MASK_ALL);
  assign busy              = (state_q != IDLE);
  assign core_load_data    = (state_q == REQ);
  assign core_enable       = (state_q == GO);
  assign res_valid         = (state_q == FIN);
  assign core_ki           = key_q[KEY_W-1];
  assign core_trigLoad     = trig_q;
  assign core_load_status  = ls_q;
  assign core_data_in      = din_q;
  assign err               = err_q;
  assign res_x             = rx_q;
  assign res_z             = rz_q;

endmodule

// File: tb/tb_bec_key_sched.sv
module tb_bec_key_sched;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [162:0] key;
  logic         busy, res_valid, err;
  logic [162:0] res_x, res_z;
  logic         core_load_data, core_enable, core_trigLoad, core_ki;
  logic [2:0]   core_load_status;
  logic [162:0] core_data_in;
  logic         core_next_key, core_done;
  logic [3:0]   core_status;
  logic [162:0] core_data_out;

  bec_key_sched_if #(.DATA_W(163)) op_if ();

  bec_key_sched #(.KEY_W(163), .DATA_W(163)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .op(op_if.slave),
    .busy(busy), .res_x(res_x), .res_z(res_z), .res_valid(res_valid), .err(err),
    .core_load_data(core_load_data), .core_enable(core_enable),
    .core_trigLoad(core_trigLoad), .core_ki(core_ki),
    .core_load_status(core_load_status), .core_data_in(core_data_in),
    .core_next_key(core_next_key), .core_done(core_done),
    .core_status(core_status), .core_data_out(core_data_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk1(input string tg, input logic o, input logic e);
    total++;
    assert (o === e) else begin bad++; $error("FAIL %s observed=%0b expected=%0b", tg, o, e); end
  endtask
  task automatic chkw(input string tg, input logic [162:0] o, input logic [162:0] e);
    total++;
    assert (o === e) else begin bad++; $error("FAIL %s observed=%0h expected=%0h", tg, o, e); end
  endtask
  task automatic chki(input string tg, input int o, input int e);
    total++;
    assert (o === e) else begin bad++; $error("FAIL %s observed=%0d expected=%0d", tg, o, e); end
  endtask

  // ---------------- core model ----------------
  logic [162:0] A, B;
  int           n_pulses;
  int           ph, dly, it;
  logic         ki_q[$];
  logic [2:0]   ld_sel[$];
  logic [162:0] ld_dat[$];

  assign core_data_out = (core_load_status == 3'd0) ? A :
                         (core_load_status == 3'd1) ? B : '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= 0; dly <= 0; it <= 0;
      core_status <= 4'b1000; core_next_key <= 1'b0; core_done <= 1'b0;
    end else begin
      core_next_key <= 1'b0;
      core_done     <= 1'b0;
      case (ph)
        0: if (core_load_data) begin
          ph <= 1; dly <= 2;
          ki_q.delete(); ld_sel.delete(); ld_dat.delete();
        end
        1: if (dly == 0) begin ph <= 2; core_status <= 4'b0100; end
           else dly <= dly - 1;
        2: begin
          if (core_trigLoad) begin
            ld_sel.push_back(core_load_status);
            ld_dat.push_back(core_data_in);
          end
          if (core_enable) begin ph <= 3; it <= 0; core_status <= 4'b0010; end
        end
        3: if (!core_next_key) begin
          if (it < n_pulses) begin
            ki_q.push_back(core_ki);   // bit presented during iteration 'it'
            core_next_key <= 1'b1;
            it <= it + 1;
          end else begin
            core_done <= 1'b1; core_status <= 4'b0001; ph <= 4;
          end
        end
        default: if (!busy) begin ph <= 0; core_status <= 4'b1000; end
      endcase
    end
  end

  // event monitor
  int cyc = 0, done_cyc = 0, rv_cyc = 0, rv_cnt = 0, en_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (core_done)   done_cyc <= cyc;
    if (res_valid)   begin rv_cyc <= cyc; rv_cnt <= rv_cnt + 1; end
    if (core_enable) en_cnt <= en_cnt + 1;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [162:0] rnd163();
    logic [191:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[162:0];
  endfunction

  task automatic do_start(input logic [162:0] k);
    @(posedge clk); #1;
    start = 1'b1; key = k;
    @(posedge clk); #1;
    start = 1'b0; key = rnd163();
  endtask

  task automatic send_op(input logic [2:0] s, input logic [162:0] d);
    int t;
    t = 0;
    op_if.op_valid = 1'b1; op_if.op_sel = s; op_if.op_data = d;
    @(negedge clk);
    while (!op_if.op_ready && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chki("op_ready_timeout", t, 0);
    @(posedge clk); #1;
    op_if.op_valid = 1'b0; op_if.op_sel = 3'd0;
    @(posedge clk); #1;          // gap cycle between operands
  endtask

  task automatic check_run(input string tg, input logic [162:0] k, input int np,
                           input logic [2:0] es[$], input logic [162:0] ed[$],
                           input logic ee, input int en0, input int rv0);
    int t;
    t = 0;
    while (rv_cnt == rv0 && t < 3000) begin @(negedge clk); t++; end
    chki({tg, ".res_valid_cnt"}, rv_cnt - rv0, 1);
    chki({tg, ".done_to_rv"}, rv_cyc - done_cyc, 3);
    chki({tg, ".enable_cnt"}, en_cnt - en0, 1);
    chk1({tg, ".busy_after"}, busy, 1'b0);
    chk1({tg, ".err"}, err, ee);
    chkw({tg, ".res_x"}, res_x, A);
    chkw({tg, ".res_z"}, res_z, B);
    chki({tg, ".n_loads"}, ld_sel.size(), es.size());
    foreach (es[i]) if (i < ld_sel.size()) begin
      chki($sformatf("%s.ld_sel%0d", tg, i), int'(ld_sel[i]), int'(es[i]));
      chkw($sformatf("%s.ld_dat%0d", tg, i), ld_dat[i], ed[i]);
    end
    chki({tg, ".n_iter"}, ki_q.size(), np);
    for (int i = 0; i < np && i < ki_q.size(); i++)
      chk1($sformatf("%s.ki%0d", tg, i), ki_q[i], k[162-i]);
  endtask

  // ---------------- main sequence ----------------
  logic [162:0] k;
  logic [2:0]   es[$];
  logic [162:0] ed[$];
  logic [2:0]   perm[6];
  logic [162:0] d;
  int           en0, rv0, t;

  initial begin
    rst = 1'b1; start = 1'b0; key = '0; n_pulses = 163;
    op_if.op_valid = 1'b0; op_if.op_sel = 3'd0; op_if.op_data = '0;
    A = 163'h1234; B = 163'h5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst.busy", busy, 1'b0);
    chk1("rst.res_valid", res_valid, 1'b0);
    chk1("rst.err", err, 1'b0);
    chk1("rst.load_data", core_load_data, 1'b0);
    chk1("rst.enable", core_enable, 1'b0);
    chk1("rst.trigload", core_trigLoad, 1'b0);
    chk1("rst.ki", core_ki, 1'b0);
    chk1("rst.op_ready", op_if.op_ready, 1'b0);
    chki("rst.load_status", int'(core_load_status), 0);
    chkw("rst.data_in", core_data_in, '0);
    chkw("rst.res_x", res_x, '0);
    chkw("rst.res_z", res_z, '0);
    rst = 1'b0;

    // run 1: sparse key, operands 5..0 with gaps
    k = '0; k[162] = 1'b1; k[0] = 1'b1;
    es.delete(); ed.delete();
    en0 = en_cnt; rv0 = rv_cnt;
    do_start(k);
    chk1("r1.busy_rise", busy, 1'b1);
    chk1("r1.load_data", core_load_data, 1'b1);
    chk1("r1.ki_at_req", core_ki, 1'b1);
    for (int i = 5; i >= 0; i--) begin
      d = rnd163(); es.push_back(3'(i)); ed.push_back(d);
      send_op(3'(i), d);
    end
    check_run("r1", k, 163, es, ed, 1'b0, en0, rv0);

    // run 2: random key/order, duplicate, illegal code, ignored start
    k = rnd163(); A = rnd163(); B = rnd163();
    for (int i = 0; i < 6; i++) perm[i] = 3'(i);
    for (int i = 5; i > 0; i--) begin
      int j; logic [2:0] tmp;
      j = int'($urandom_range(i, 0));
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    es.delete(); ed.delete();
    en0 = en_cnt; rv0 = rv_cnt;
    do_start(k);
    do_start(~k);                       // busy: must be ignored
    d = rnd163(); es.push_back(perm[0]); ed.push_back(d); send_op(perm[0], d);
    d = rnd163(); es.push_back(perm[0]); ed.push_back(d); send_op(perm[0], d);
    send_op(3'd7, rnd163());
    chk1("r2.err_illegal", err, 1'b1);
    for (int i = 1; i < 6; i++) begin
      d = rnd163(); es.push_back(perm[i]); ed.push_back(d); send_op(perm[i], d);
    end
    check_run("r2", k, 163, es, ed, 1'b1, en0, rv0);

    // run 3: normal random run, start must clear err
    k = rnd163(); A = rnd163(); B = rnd163();
    es.delete(); ed.delete();
    en0 = en_cnt; rv0 = rv_cnt;
    do_start(k);
    chk1("r3.err_cleared", err, 1'b0);
    for (int i = 0; i < 6; i++) begin
      d = rnd163(); es.push_back(3'(i)); ed.push_back(d); send_op(3'(i), d);
    end
    check_run("r3", k, 163, es, ed, 1'b0, en0, rv0);

    // run 4: reset in the middle of RUN, then a clean run
    k = rnd163();
    rv0 = rv_cnt;
    do_start(k);
    for (int i = 0; i < 6; i++) send_op(3'(i), rnd163());
    t = 0;
    while (ki_q.size() < 10 && t < 2000) begin @(negedge clk); t++; end
    chki("r4.reach_run", (ki_q.size() >= 10) ? 1 : 0, 1);
    rst = 1'b1; #1;
    chk1("r4.busy", busy, 1'b0);
    chk1("r4.enable", core_enable, 1'b0);
    chkw("r4.res_x", res_x, '0);
    @(negedge clk); rst = 1'b0;
    repeat (400) @(negedge clk);
    chki("r4.no_res_valid", rv_cnt - rv0, 0);
    k = rnd163(); A = rnd163(); B = rnd163();
    es.delete(); ed.delete();
    en0 = en_cnt; rv0 = rv_cnt;
    do_start(k);
    for (int i = 0; i < 6; i++) begin
      d = rnd163(); es.push_back(3'(5 - i)); ed.push_back(d); send_op(3'(5 - i), d);
    end
    check_run("r4b", k, 163, es, ed, 1'b0, en0, rv0);

    // run 5: core issues one pulse short
    n_pulses = 162;
    k = rnd163(); A = rnd163(); B = rnd163();
    es.delete(); ed.delete();
    en0 = en_cnt; rv0 = rv_cnt;
    do_start(k);
    for (int i = 0; i < 6; i++) begin
      d = rnd163(); es.push_back(3'(i)); ed.push_back(d); send_op(3'(i), d);
    end
`ifdef BEC_SCHED_ITERCHK_EN
    check_run("r5", k, 162, es, ed, 1'b1, en0, rv0);
`else
    check_run("r5", k, 162, es, ed, 1'b0, en0, rv0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
